// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and defaults for the pipeline handshake slices.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int PIPE_DW = 32;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_BUSY  = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_skid_slice.sv
// ============================================================================
// Module  : pipeline_skid_slice
// Brief   : Fully-registered valid/ready slice with a main+skid entry pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_skid_slice
  import pipeline_pkg::*;
#(
  parameter int DW = PIPE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic [1:0]    occupancy
);

  localparam logic [1:0] ST_EMPTY = SK_EMPTY;
  localparam logic [1:0] ST_BUSY  = SK_BUSY;
  localparam logic [1:0] ST_FULL  = SK_FULL;

  logic [1:0]    r_state;
  logic          r_in_ready;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;

  logic [1:0]    w_next_state;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_load_main_in;
  logic          w_load_main_skid;
  logic          w_load_skid;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_load_main_in = 1'b1;
          w_next_state   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid  = 1'b1;
          w_next_state = ST_FULL;
        end else if (w_out_fire) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_load_main_skid = 1'b1;
          w_next_state     = ST_BUSY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // Ready is registered from the next state, so upstream never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
      if (w_load_main_in) begin
        r_main <= data_in;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= data_in;
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_BUSY) || (r_state == ST_FULL);
  assign data_out  = r_main;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_skid_slice.sv
// ============================================================================
// Module  : tb_pipeline_skid_slice
// Brief   : Self-checking bench for pipeline_skid_slice against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_skid_slice;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of at most two words plus a registered ready bit.
  logic [DW-1:0] m_q[$];
  bit            m_rdy;
  bit            pend_in;
  bit            pend_out;
  logic [DW-1:0] pend_data;
  int            n_in  = 0;
  int            n_out = 0;

  pipeline_skid_slice #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_rdy    = 1'b0;
      pend_in  = 1'b0;
      pend_out = 1'b0;
    end else begin
      if (pend_out) begin
        void'(m_q.pop_front());
        n_out++;
      end
      if (pend_in) begin
        m_q.push_back(pend_data);
        n_in++;
      end
      m_rdy    = (m_q.size() < 2);
      pend_in  = 1'b0;
      pend_out = 1'b0;
    end
  end

  // Compare on the falling edge, then latch what will transfer on the next rising edge.
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(m_q.size()));
    chk("in_ready",  64'(in_ready),  64'(m_rdy));
    if (m_q.size() != 0) chk("data_out", 64'(data_out), 64'(m_q[0]));
    pend_in   = in_valid && m_rdy && !rst;
    pend_out  = (m_q.size() != 0) && out_ready && !rst;
    pend_data = data_in;
  end

  assert property (@(posedge clk) disable iff (rst)
                   (out_valid && !out_ready) |=> (out_valid && $stable(data_out)))
  else begin
    n_fail++;
    $display("FAIL stability: out_valid/data_out changed while stalled at %0t", $time);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    step();
    step();
    rst = 1'b0;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    chk("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // T2: back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      data_in  = DW'(i);
      step();
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_data_out", 64'(data_out), 64'(i));
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(n_in), 64'd16);
    step();
    step();

    // T3: fill under stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'hA;
    step();
    chk("fill_occ1", 64'(occupancy), 64'd1);
    data_in = 32'hB;
    step();
    chk("fill_occ2", 64'(occupancy), 64'd2);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    data_in = 32'hC;
    step();
    step();
    chk("fill_hold_data", 64'(data_out), 64'hA);
    chk("fill_hold_occ", 64'(occupancy), 64'd2);

    // T4: drain A, B, C on consecutive cycles
    out_ready = 1'b1;
    step();
    chk("drain_B", 64'(data_out), 64'hB);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("drain_C", 64'(data_out), 64'hC);
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // T6: simultaneous in/out fire while holding one entry
    in_valid = 1'b1;
    data_in  = 32'h1234;
    step();
    data_in = 32'hDEAD;
    step();
    chk("sim_occ_dead", 64'(occupancy), 64'd1);
    chk("sim_data_dead", 64'(data_out), 64'hDEAD);
    data_in = 32'hBEEF;
    step();
    chk("sim_occ_beef", 64'(occupancy), 64'd1);
    chk("sim_data_beef", 64'(data_out), 64'hBEEF);
    in_valid = 1'b0;
    step();
    step();

    // T5: random traffic
    begin
      int base;
      int cyc;
      base = n_in;
      cyc  = 0;
      while ((n_in - base) < 10000 && cyc < 60000) begin
        in_valid  = $urandom_range(0, 1) == 1;
        data_in   = DW'($urandom);
        out_ready = $urandom_range(0, 1) == 1;
        step();
        cyc++;
      end
      chk("rand_words_sent", 64'(n_in - base), 64'd10000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rand_no_loss", 64'(n_out), 64'(n_in));
    chk("rand_drained_occ", 64'(occupancy), 64'd0);

    // T1: reset mid-stream with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h55;
    step();
    data_in = 32'h66;
    step();
    in_valid = 1'b0;
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("post_rst_in_ready_low", 64'(in_ready), 64'd0);
    step();
    chk("post_rst_in_ready_high", 64'(in_ready), 64'd1);
    chk("post_rst_no_replay", 64'(out_valid), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
